// File: rtl/mipi_raw_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mipi_raw_pkg
// Desc     : CSI-2 RAW data types, unpacker FSM states and data-type decode.
//            DT 0x2C decodes to RAW12 only when MIPI_RAW_UNPACK_RAW12_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
package mipi_raw_pkg;

    localparam logic [5:0] DT_RAW8  = 6'h2A;
    localparam logic [5:0] DT_RAW10 = 6'h2B;
    localparam logic [5:0] DT_RAW12 = 6'h2C;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        SKIP
    } unpack_state_t;

    typedef enum logic [1:0] {
        FMT_NONE,
        FMT_RAW8,
        FMT_RAW10,
        FMT_RAW12
    } raw_format_t;

    function automatic raw_format_t dt_to_format(input logic [5:0] dt);
        raw_format_t fmt;
        case (dt)
            DT_RAW8:  fmt = FMT_RAW8;
            DT_RAW10: fmt = FMT_RAW10;
`ifdef MIPI_RAW_UNPACK_RAW12_EN
            DT_RAW12: fmt = FMT_RAW12;
`endif
            default:  fmt = FMT_NONE;
        endcase
        return fmt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mipi_raw_byte_buffer.sv
`default_nettype none
// ============================================================================
// Module   : mipi_raw_byte_buffer
// Desc     : 8-byte shift buffer; drops `consume` oldest bytes, then appends
//            `append` bytes from din in the same cycle. Byte [0] is oldest.
// Revision : 1.0 - initial release
// ============================================================================
module mipi_raw_byte_buffer #(
    parameter int NUM_BYTES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic [3:0]                consume,
    input  logic [3:0]                append,
    input  logic [NUM_BYTES-1:0][7:0] din,
    output logic [7:0][7:0]           bytes,
    output logic [3:0]                fill
);

    logic [7:0][7:0] r_data;
    logic [3:0]      r_fill;
    logic [7:0][7:0] w_next;
    logic [3:0]      w_base;
    logic [2:0]      w_pos;

    always_comb begin
        w_next = r_data >> {consume, 3'b000};
        w_base = r_fill - consume;
        w_pos  = '0;
        for (int j = 0; j < NUM_BYTES; j++) begin
            w_pos = w_base[2:0] + 3'(j);
            if (4'(j) < append) begin
                w_next[w_pos] = din[j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_fill <= '0;
        end else if (clear) begin
            r_data <= '0;
            r_fill <= '0;
        end else begin
            r_data <= w_next;
            r_fill <= w_base + append;
        end
    end

    assign bytes = r_data;
    assign fill  = r_fill;

endmodule

`default_nettype wire

// File: rtl/mipi_raw_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : mipi_raw_unpacker
// Desc     : CSI-2 RAW8/RAW10 byte stream to MSB-aligned 4-pixel groups.
//            RAW12 path is built only with MIPI_RAW_UNPACK_RAW12_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
module mipi_raw_unpacker
    import mipi_raw_pkg::*;
#(
    parameter int NUM_BYTES   = 4,
    parameter int PIXEL_WIDTH = 8
) (
    input  logic                        mipi_clk,
    input  logic                        resetn,
    input  logic [NUM_BYTES-1:0][7:0]   image_data,
    input  logic [5:0]                  image_data_type,
    input  logic                        image_data_enable,
    input  logic [15:0]                 word_count,
    input  logic                        line_start,
    input  logic                        frame_start,
    output logic [3:0][PIXEL_WIDTH-1:0] pixels,
    output logic [2:0]                  pixel_count,
    output logic                        pixel_valid,
    output logic                        align_err,
    output logic                        type_err
);

    localparam logic [3:0] c_num_bytes = 4'(NUM_BYTES);

    if (!(NUM_BYTES == 2 || NUM_BYTES == 4)) begin : g_bad_num_bytes
        $error("mipi_raw_unpacker: NUM_BYTES must be 2 or 4");
    end
    if (!(PIXEL_WIDTH == 8 || PIXEL_WIDTH == 10 || PIXEL_WIDTH == 12)) begin : g_bad_pixel_width
        $error("mipi_raw_unpacker: PIXEL_WIDTH must be 8, 10 or 12");
    end

    unpack_state_t   r_state;
    raw_format_t     r_fmt;
    logic [15:0]     r_count;

    logic [7:0][7:0] w_bytes;
    logic [3:0]      w_fill;
    logic [3:0]      w_take;
    logic [3:0]      w_consume;
    logic [3:0]      w_left;
    logic            w_clear;
    logic            w_sync;
    logic            w_intake;
    logic [15:0]     w_remaining;
    raw_format_t     w_in_fmt;
    logic [3:0][11:0] w_pix12;
    logic [2:0]      w_npix;
    logic            w_unused;

    assign w_sync   = line_start | frame_start;
    assign w_in_fmt = dt_to_format(image_data_type);
    assign w_unused = ^w_bytes[7:5];

    // Intake: the first word of a packet is counted against word_count directly.
    always_comb begin
        w_intake    = 1'b0;
        w_remaining = r_count;
        if (!w_sync && image_data_enable) begin
            if (r_state == IDLE && w_in_fmt != FMT_NONE) begin
                w_intake    = 1'b1;
                w_remaining = word_count;
            end else if (r_state == ACTIVE) begin
                w_intake = 1'b1;
            end
        end
        w_take = '0;
        if (w_intake) begin
            w_take = (w_remaining >= 16'(NUM_BYTES)) ? c_num_bytes : w_remaining[3:0];
        end
    end

    // Pixels are built 12 bits wide, MSB-aligned, then cut to PIXEL_WIDTH.
    always_comb begin
        w_pix12   = '0;
        w_npix    = '0;
        w_consume = '0;
        if (r_state == ACTIVE && !w_sync) begin
            case (r_fmt)
                FMT_RAW8: begin
                    w_consume = (w_fill >= c_num_bytes) ? c_num_bytes : w_fill;
                    for (int i = 0; i < NUM_BYTES; i++) begin
                        if (4'(i) < w_consume) begin
                            w_pix12[i] = {w_bytes[i], 4'h0};
                        end
                    end
                    w_npix = w_consume[2:0];
                end
                FMT_RAW10: begin
                    if (w_fill >= 4'd5) begin
                        w_consume = 4'd5;
                        w_npix    = 3'd4;
                        for (int i = 0; i < 4; i++) begin
                            w_pix12[i] = {w_bytes[i], w_bytes[4][2*i +: 2], 2'b00};
                        end
                    end
                end
`ifdef MIPI_RAW_UNPACK_RAW12_EN
                FMT_RAW12: begin
                    if (w_fill >= 4'd6) begin
                        w_consume  = 4'd6;
                        w_npix     = 3'd4;
                        w_pix12[0] = {w_bytes[0], w_bytes[2][3:0]};
                        w_pix12[1] = {w_bytes[1], w_bytes[2][7:4]};
                        w_pix12[2] = {w_bytes[3], w_bytes[5][3:0]};
                        w_pix12[3] = {w_bytes[4], w_bytes[5][7:4]};
                    end else if (w_fill >= 4'd3) begin
                        w_consume  = 4'd3;
                        w_npix     = 3'd2;
                        w_pix12[0] = {w_bytes[0], w_bytes[2][3:0]};
                        w_pix12[1] = {w_bytes[1], w_bytes[2][7:4]};
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign w_left  = w_fill - w_consume;
    assign w_clear = w_sync || (r_state == ACTIVE && !image_data_enable);

    mipi_raw_byte_buffer #(
        .NUM_BYTES (NUM_BYTES)
    ) u_buffer (
        .clk     (mipi_clk),
        .rst_n   (resetn),
        .clear   (w_clear),
        .consume (w_consume),
        .append  (w_take),
        .din     (image_data),
        .bytes   (w_bytes),
        .fill    (w_fill)
    );

    always_ff @(posedge mipi_clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_fmt       <= FMT_NONE;
            r_count     <= '0;
            pixels      <= '0;
            pixel_count <= '0;
            pixel_valid <= 1'b0;
            align_err   <= 1'b0;
            type_err    <= 1'b0;
        end else begin
            pixel_valid <= (w_npix != 3'd0);
            pixel_count <= w_npix;
            for (int i = 0; i < 4; i++) begin
                pixels[i] <= w_pix12[i][11 -: PIXEL_WIDTH];
            end

            if (frame_start) begin
                align_err <= 1'b0;
                type_err  <= 1'b0;
            end else if (!line_start) begin
                if (r_state == ACTIVE && !image_data_enable && w_left != 4'd0) begin
                    align_err <= 1'b1;
                end
                if (r_state == IDLE && image_data_enable && w_in_fmt == FMT_NONE) begin
                    type_err <= 1'b1;
                end
            end

            if (w_sync) begin
                r_state <= IDLE;
                r_count <= '0;
            end else begin
                if (w_intake) begin
                    r_count <= w_remaining - {12'd0, w_take};
                end
                case (r_state)
                    IDLE: begin
                        if (image_data_enable) begin
                            if (w_in_fmt != FMT_NONE) begin
                                r_state <= ACTIVE;
                                r_fmt   <= w_in_fmt;
                            end else begin
                                r_state <= SKIP;
                            end
                        end
                    end
                    ACTIVE, SKIP: begin
                        if (!image_data_enable) begin
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mipi_raw_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : tb_mipi_raw_unpacker
// Desc     : Scoreboard bench for mipi_raw_unpacker (NUM_BYTES=4, PIXEL_WIDTH=10);
//            RAW12 expectations follow MIPI_RAW_UNPACK_RAW12_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mipi_raw_unpacker;

    logic            clk = 1'b0;
    logic            resetn;
    logic [3:0][7:0] image_data;
    logic [5:0]      image_data_type;
    logic            image_data_enable;
    logic [15:0]     word_count;
    logic            line_start;
    logic            frame_start;
    logic [3:0][9:0] pixels;
    logic [2:0]      pixel_count;
    logic            pixel_valid;
    logic            align_err;
    logic            type_err;

    int n_tests = 0;
    int n_fail  = 0;
    int beats   = 0;
    int exp_beats;
    bit m_align = 1'b0;
    bit m_type  = 1'b0;
    logic [7:0] pl[$];
    logic [9:0] exp_px[$];

    mipi_raw_unpacker #(
        .NUM_BYTES   (4),
        .PIXEL_WIDTH (10)
    ) dut (
        .mipi_clk          (clk),
        .resetn            (resetn),
        .image_data        (image_data),
        .image_data_type   (image_data_type),
        .image_data_enable (image_data_enable),
        .word_count        (word_count),
        .line_start        (line_start),
        .frame_start       (frame_start),
        .pixels            (pixels),
        .pixel_count       (pixel_count),
        .pixel_valid       (pixel_valid),
        .align_err         (align_err),
        .type_err          (type_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: whole-packet pixel list derived from the format's packing rules.
    function automatic void model_packet(input logic [5:0] dt, input int wc);
        logic [7:0]  b4;
        logic [11:0] p;
        exp_beats = 0;
        if (dt == 6'h2A) begin
            for (int i = 0; i < wc; i++) exp_px.push_back({pl[i], 2'b00});
            exp_beats = (wc + 3) / 4;
        end else if (dt == 6'h2B) begin
            for (int g = 0; g < wc / 5; g++) begin
                b4 = pl[5*g+4];
                for (int i = 0; i < 4; i++) exp_px.push_back({pl[5*g+i], b4[2*i +: 2]});
            end
            exp_beats = wc / 5;
            if (wc % 5 != 0) m_align = 1'b1;
`ifdef MIPI_RAW_UNPACK_RAW12_EN
        end else if (dt == 6'h2C) begin
            for (int g = 0; g < wc / 3; g++) begin
                b4 = pl[3*g+2];
                p  = {pl[3*g], b4[3:0]};
                exp_px.push_back(p[11:2]);
                p  = {pl[3*g+1], b4[7:4]};
                exp_px.push_back(p[11:2]);
            end
            exp_beats = -1;
            if (wc % 3 != 0) m_align = 1'b1;
`endif
        end else begin
            m_type = 1'b1;
        end
    endfunction

    // Monitor: pops one expected pixel per presented pixel.
    always @(negedge clk) begin
        if (resetn && pixel_valid) begin
            beats++;
            check("count_range", 32'(pixel_count >= 3'd1 && pixel_count <= 3'd4), 32'd1);
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < pixel_count) begin
                    if (exp_px.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_pixel: got %0h expected none", pixels[i]);
                    end else begin
                        check("pixel", 32'(pixels[i]), 32'(exp_px.pop_front()));
                    end
                end
            end
        end
    end

    // pulse: 0 none, 1 line_start, 2 frame_start. extra: padding words after payload.
    task automatic run_packet(input logic [5:0] dt, input int wc, input int pulse, input int extra);
        int nwords;
        if (pulse != 0) begin
            if (pulse == 2) frame_start = 1'b1;
            else            line_start  = 1'b1;
            @(posedge clk); #1;
            frame_start = 1'b0;
            line_start  = 1'b0;
            if (pulse == 2) begin
                m_align = 1'b0;
                m_type  = 1'b0;
            end
            check("err_after_pulse", {30'd0, align_err, type_err}, {30'd0, m_align, m_type});
        end
        while (pl.size() < wc) pl.push_back(8'($urandom));
        model_packet(dt, wc);
        beats  = 0;
        nwords = (wc + 3) / 4 + extra;
        for (int w = 0; w < nwords; w++) begin
            for (int k = 0; k < 4; k++) begin
                image_data[k] = (4*w + k < wc) ? pl[4*w+k] : 8'($urandom);
            end
            image_data_enable = 1'b1;
            image_data_type   = dt;
            word_count        = 16'(wc);
            @(posedge clk); #1;
        end
        image_data_enable = 1'b0;
        image_data        = $urandom;
        repeat (4) @(posedge clk);
        #1;
        check("pixels_drained", 32'(exp_px.size()), 32'd0);
        if (exp_beats >= 0) check("beat_count", 32'(beats), 32'(exp_beats));
        check("align_err", 32'(align_err), 32'(m_align));
        check("type_err", 32'(type_err), 32'(m_type));
        exp_px.delete();
        pl.delete();
    endtask

    task automatic load_s2();
        pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hE4, 8'h11, 8'h22, 8'h33, 8'h44, 8'h1B};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        resetn            = 1'b0;
        image_data        = '0;
        image_data_type   = '0;
        image_data_enable = 1'b0;
        word_count        = '0;
        line_start        = 1'b0;
        frame_start       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pixels", 32'(pixels), 32'd0);
        check("rst_flags", {27'd0, pixel_count, pixel_valid, align_err}, 32'd0);
        check("rst_type_err", 32'(type_err), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        pl = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        run_packet(6'h2A, 8, 2, 0);
        load_s2();
        run_packet(6'h2B, 10, 1, 0);
        run_packet(6'h2B, 7, 1, 0);
        run_packet(6'h24, 12, 2, 0);
        run_packet(6'h2A, 6, 2, 1);

        // Reset while 3 RAW10 bytes sit in the buffer.
        line_start = 1'b1;
        @(posedge clk); #1;
        line_start        = 1'b0;
        image_data        = $urandom;
        image_data_type   = 6'h2B;
        word_count        = 16'd3;
        image_data_enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        resetn            = 1'b0;
        image_data_enable = 1'b0;
        @(negedge clk);
        check("midrst_pixels", 32'(pixels), 32'd0);
        check("midrst_flags", {27'd0, pixel_count, pixel_valid, align_err}, 32'd0);
        check("midrst_type_err", 32'(type_err), 32'd0);
        @(posedge clk); #1;
        resetn  = 1'b1;
        m_align = 1'b0;
        m_type  = 1'b0;
        exp_px.delete();
        @(posedge clk); #1;
        check("post_rst_valid", 32'(pixel_valid), 32'd0);
        load_s2();
        run_packet(6'h2B, 10, 0, 0);

`ifdef MIPI_RAW_UNPACK_RAW12_EN
        load_s2();
        run_packet(6'h2C, 9, 2, 0);
`endif

        for (int n = 0; n < 40; n++) begin
            logic [5:0] dt;
            case ($urandom_range(0, 4))
                0:       dt = 6'h2A;
                1:       dt = 6'h2B;
                2:       dt = 6'h2C;
                3:       dt = 6'h24;
                default: dt = 6'h12;
            endcase
            run_packet(dt, int'($urandom_range(1, 40)), int'($urandom_range(0, 2)),
                       int'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
